// File: rtl/proc_control_unit.sv
// Control FSM for the programmable processor: fetches and decodes 16-bit
// instructions and drives the register file, ALU and data memory controls.
module proc_control_unit #(
   parameter int PC_W = 7,
   parameter int DA_W = 8
) (
   input  logic            Clk,
   input  logic            ResetN,
   input  logic            Run,
   input  logic [15:0]     IR_Data,
   output logic [PC_W-1:0] PC_Addr,
   output logic [DA_W-1:0] D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_addr,
   output logic [3:0]      RF_Rb_addr,
   output logic [2:0]      ALU_s,
   output logic            Halted,
   output logic            Illegal
);

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_NOOP,
      S_LOAD_A,
      S_LOAD_B,
      S_STORE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            illegal_q, illegal_d;
   logic [3:0]      op;
   logic [3:0]      next_op;

   assign op      = ir_q[15:12];
   assign next_op = IR_Data[15:12];
   assign PC_Addr = pc_q;
   assign Halted  = (state_q == S_HALT);
   assign Illegal = illegal_q;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q   <= S_INIT;
         pc_q      <= '0;
         ir_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      illegal_d  = illegal_q;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s      = 3'd0;
      unique case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            if (Run) state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d = IR_Data;
            pc_d = pc_q + 1'b1;
            case (next_op)
               4'h1:    state_d = S_LOAD_A;
               4'h2:    state_d = S_STORE;
               4'h3, 4'h4, 4'h5, 4'h6,
               4'h7, 4'h8, 4'h9:
                        state_d = S_EXEC;
               4'hF:    state_d = S_HALT;
               default: state_d = S_NOOP;
            endcase
         end
         S_NOOP: begin
            state_d = S_FETCH;
            if (op >= 4'hA && op <= 4'hE) illegal_d = 1'b1;
         end
         S_LOAD_A: begin
            D_Addr  = ir_q[4 +: DA_W];
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            D_Addr    = ir_q[4 +: DA_W];
            RF_s      = 1'b1;
            RF_W_addr = ir_q[3:0];
            RF_W_en   = 1'b1;
            state_d   = S_FETCH;
         end
         S_STORE: begin
            // write data reaches memory through RF port A via ALU pass-A
            D_Addr     = ir_q[4 +: DA_W];
            RF_Ra_addr = ir_q[3:0];
            ALU_s      = 3'd3;
            D_Wr       = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXEC: begin
            RF_Ra_addr = ir_q[11:8];
            RF_Rb_addr = ir_q[7:4];
            RF_W_addr  = ir_q[3:0];
            RF_W_en    = 1'b1;
            case (op)
               4'h3:    ALU_s = 3'd1;
               4'h4:    ALU_s = 3'd2;
               4'h5:    ALU_s = 3'd4;
               4'h6:    ALU_s = 3'd5;
               4'h7:    ALU_s = 3'd6;
               4'h8:    ALU_s = 3'd7;
               4'h9:    ALU_s = 3'd3;
               default: ALU_s = 3'd0;
            endcase
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_proc_control_unit.sv
// Randomized bench for proc_control_unit: per-instruction cycle traces
// derived from the ISA are compared against the DUT outputs every cycle.
module tb_proc_control_unit;

   logic        Clk = 1'b0;
   logic        ResetN = 1'b1;
   logic        Run = 1'b0;
   logic [15:0] IR_Data = 16'h0;
   logic [6:0]  PC_Addr;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  ALU_s;
   logic        Halted;
   logic        Illegal;

   proc_control_unit #(.PC_W(7), .DA_W(8)) dut (
      .Clk(Clk), .ResetN(ResetN), .Run(Run), .IR_Data(IR_Data),
      .PC_Addr(PC_Addr), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .ALU_s(ALU_s), .Halted(Halted), .Illegal(Illegal)
   );

   always #5 Clk = ~Clk;

   logic [15:0] rom [128];
   always @(posedge Clk) IR_Data <= rom[PC_Addr];

   int checks = 0;
   int failures = 0;
   int m_pc = 0;
   bit m_ill = 1'b0;

   wire [34:0] obs = {PC_Addr, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
                      RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, Illegal};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
      end
   endtask

   function automatic logic [34:0] pk(int pc, int da, bit dwr, bit rfs,
      int wa, bit wen, int ra, int rb, int alu, bit h, bit il);
      pk = {7'(pc), 8'(da), dwr, rfs, 4'(wa), wen, 4'(ra), 4'(rb),
            3'(alu), h, il};
   endfunction

   function automatic logic [34:0] idle(int pc, bit il);
      idle = pk(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, il);
   endfunction

   function automatic int alu_of(int op);
      case (op)
         3: alu_of = 1;   // ADD
         4: alu_of = 2;   // SUB
         5: alu_of = 4;   // XOR
         6: alu_of = 5;   // OR
         7: alu_of = 6;   // AND
         8: alu_of = 7;   // INC
         9: alu_of = 3;   // MOVE
         default: alu_of = 0;
      endcase
   endfunction

   task automatic do_reset();
      @(posedge Clk);
      #3 ResetN = 1'b0;
      #1 chk("reset_async", obs, 0);
      @(negedge Clk);
      chk("reset_hold", obs, 0);
      ResetN = 1'b1;
      m_pc = 0;
      m_ill = 1'b0;
   endtask

   task automatic run_instr(input int halt_cycles, output bit halted);
      logic [15:0] ins;
      int op, addr, rd, ra, rb, np, hold;
      ins  = rom[m_pc];
      op   = int'(ins[15:12]);
      addr = int'(ins[11:4]);
      rd   = int'(ins[3:0]);
      ra   = int'(ins[11:8]);
      rb   = int'(ins[7:4]);
      np   = (m_pc + 1) % 128;
      hold = $urandom_range(0, 2);
      halted = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         @(negedge Clk);
         chk("fetch", obs, idle(m_pc, m_ill));
         Run = (i < hold) ? 1'b0 : 1'b1;
      end
      @(negedge Clk);
      chk("decode", obs, idle(m_pc, m_ill));
      Run = 1'($urandom_range(0, 1));
      if (op == 1) begin
         @(negedge Clk);
         chk("load_a", obs, pk(np, addr, 0, 0, 0, 0, 0, 0, 0, 0, m_ill));
         @(negedge Clk);
         chk("load_b", obs, pk(np, addr, 0, 1, rd, 1, 0, 0, 0, 0, m_ill));
      end else if (op == 2) begin
         @(negedge Clk);
         chk("store", obs, pk(np, addr, 1, 0, 0, 0, rd, 0, 3, 0, m_ill));
      end else if (op >= 3 && op <= 9) begin
         @(negedge Clk);
         chk("exec", obs,
             pk(np, 0, 0, 0, rd, 1, ra, rb, alu_of(op), 0, m_ill));
      end else if (op == 15) begin
         for (int i = 0; i < halt_cycles; i++) begin
            @(negedge Clk);
            chk("halt", obs, pk(np, 0, 0, 0, 0, 0, 0, 0, 0, 1, m_ill));
            Run = 1'($urandom_range(0, 1));
         end
         halted = 1'b1;
      end else begin
         @(negedge Clk);
         chk("noop", obs, idle(np, m_ill));
         if (op >= 10) m_ill = 1'b1;
      end
      m_pc = np;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 128; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h0;
         rom[i] = w;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
   endtask

   bit h;

   initial begin
      clear_rom();
      #2 ResetN = 1'b0;
      #1 chk("reset_start", obs, 0);

      // ADD R5 = R1 + R2, then NOOP at PC 1
      rom[0] = 16'h3125;
      do_reset();
      run_instr(0, h);
      run_instr(0, h);

      // LOAD R3 = D[0xA7]
      clear_rom();
      rom[0] = 16'h1A73;
      do_reset();
      run_instr(0, h);
      run_instr(0, h);

      // STORE D[0x40] = R6
      clear_rom();
      rom[0] = 16'h2406;
      do_reset();
      run_instr(0, h);
      run_instr(0, h);

      // illegal opcode then HALT
      clear_rom();
      rom[0] = 16'hB000;
      rom[1] = 16'hF000;
      do_reset();
      run_instr(0, h);
      chk("illegal_sticky", 64'(m_ill), 64'd1);
      run_instr(22, h);
      chk("halt_reached", 64'(h), 64'd1);
      chk("halt_pc", 64'(PC_Addr), 64'd2);
      chk("halt_illegal", 64'(Illegal), 64'd1);

      // PC wraps after 128 NOOPs; then Run=0 holds in FETCH
      clear_rom();
      do_reset();
      for (int i = 0; i < 128; i++) run_instr(0, h);
      @(negedge Clk);
      chk("pc_wrap", 64'(PC_Addr), 64'd0);
      Run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         chk("run_hold", obs, idle(0, 1'b0));
      end

      // reset while in LOAD_B aborts the register write
      clear_rom();
      rom[0] = 16'h1A73;
      do_reset();
      @(negedge Clk);
      chk("ab_fetch", obs, idle(0, 1'b0));
      Run = 1'b1;
      @(negedge Clk);
      chk("ab_decode", obs, idle(0, 1'b0));
      @(negedge Clk);
      chk("ab_load_a", obs, pk(1, 8'hA7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      #2 chk("ab_load_b", obs, pk(1, 8'hA7, 0, 1, 3, 1, 0, 0, 0, 0, 0));
      ResetN = 1'b0;
      #1 chk("abort_load_b", obs, 0);
      @(negedge Clk);
      ResetN = 1'b1;
      m_pc = 0;
      m_ill = 1'b0;
      run_instr(0, h);

      // random programs with random Run stalls
      fill_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         run_instr(4, h);
         if (h) begin
            fill_random();
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
